// File: rtl/vga_timing_pkg.sv
// -----------------------------------------------------------------------------
// vga_timing_pkg
//   Shared constants and helpers for the VGA raster timing generator.
//   - Default 640x480@60 timing (25.175 MHz pixel rate) used as parameter
//     defaults by vga_timing_gen.
//   - Helpers that derive the total line/frame length and the sync window
//     bounds from the four segment lengths (active, front porch, sync, back
//     porch), plus a sanity check used at elaboration time.
// -----------------------------------------------------------------------------
package vga_timing_pkg;

  // Default horizontal timing (pixels)
  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FP     = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BP     = 48;

  // Default vertical timing (lines)
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BP     = 33;

  // Default counter widths
  localparam int unsigned DEF_CNT_W    = 10;
  localparam int unsigned DEF_FRAME_W  = 8;

  // Total length of one line or one frame: segments are laid out as
  // active, front porch, sync, back porch.
  function automatic int unsigned calc_total(
    input int unsigned active,
    input int unsigned fp,
    input int unsigned sync,
    input int unsigned bp
  );
    return active + fp + sync + bp;
  endfunction

  // First count value inside the sync window.
  function automatic int unsigned sync_first(
    input int unsigned active,
    input int unsigned fp
  );
    return active + fp;
  endfunction

  // Last count value inside the sync window (inclusive).
  function automatic int unsigned sync_last(
    input int unsigned active,
    input int unsigned fp,
    input int unsigned sync
  );
    return active + fp + sync - 1;
  endfunction

  // True when every segment is non-empty and the largest count value
  // (total-1) fits in a cnt_w-bit counter.
  function automatic bit params_ok(
    input int unsigned active,
    input int unsigned fp,
    input int unsigned sync,
    input int unsigned bp,
    input int unsigned cnt_w
  );
    longint unsigned total_m1;
    longint unsigned limit;
    if (active == 0 || fp == 0 || sync == 0 || bp == 0) begin
      return 1'b0;
    end
    total_m1 = longint'(calc_total(active, fp, sync, bp)) - 1;
    limit    = (64'd1 << cnt_w) - 1;
    return total_m1 <= limit;
  endfunction

  // Default sync windows (656..751 horizontally, 490..491 vertically)
  localparam int unsigned DEF_HS_FIRST = sync_first(DEF_H_ACTIVE, DEF_H_FP);
  localparam int unsigned DEF_HS_LAST  = sync_last(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC);
  localparam int unsigned DEF_VS_FIRST = sync_first(DEF_V_ACTIVE, DEF_V_FP);
  localparam int unsigned DEF_VS_LAST  = sync_last(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC);

endpackage

// File: rtl/wrap_counter.sv
// -----------------------------------------------------------------------------
// wrap_counter
//   Modulo-(MAX+1) up counter. Advances on clock edges with inc=1 and wraps
//   from MAX back to 0. Resets to MAX so that the first increment after reset
//   lands on 0.
//   Ports:
//     clk     in   system clock
//     rst_n   in   asynchronous active-low reset
//     inc     in   advance by one on this edge
//     count   out  current value, 0..MAX
//     at_max  out  registered flag, high while count==MAX
// -----------------------------------------------------------------------------
module wrap_counter
  import vga_timing_pkg::*;
#(
  parameter int unsigned MAX = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP - 1,
  parameter int unsigned W   = DEF_CNT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count,
  output logic         at_max
);

  localparam logic [W-1:0] MAX_V = W'(MAX);

  logic [W-1:0] count_next;

  always_comb begin
    count_next = count;
    if (inc) begin
      count_next = at_max ? '0 : count + 1'b1;
    end
  end

  // at_max is computed from the next value so it is already valid in the
  // cycle the counter shows MAX; users need no extra comparator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= MAX_V;
      at_max <= 1'b1;
    end else begin
      count  <= count_next;
      at_max <= (count_next == MAX_V);
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
//   Parametrised VGA raster timing generator. A horizontal and a vertical
//   wrap_counter form the raster position; sync, active and strobe outputs
//   are registered from the position the counters move to on the same edge,
//   so every decoded output lines up with the h_count/v_count it describes.
//   Ports:
//     clk          in   system clock
//     rst_n        in   asynchronous active-low reset
//     en           in   pixel-rate enable; state advances only when high
//     h_count      out  pixel position in line, 0..H_TOTAL-1
//     v_count      out  line position in frame, 0..V_TOTAL-1
//     hsync        out  horizontal sync, asserted level = H_SYNC_POL
//     vsync        out  vertical sync, asserted level = V_SYNC_POL
//     active       out  high inside the visible area
//     line_end     out  high while h_count==H_TOTAL-1
//     frame_start  out  high while h_count==0 and v_count==0
//     frame_cnt    out  completed-frame count, wraps modulo 2^FRAME_W
// -----------------------------------------------------------------------------
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE   = DEF_H_ACTIVE,
  parameter int unsigned H_FP       = DEF_H_FP,
  parameter int unsigned H_SYNC     = DEF_H_SYNC,
  parameter int unsigned H_BP       = DEF_H_BP,
  parameter int unsigned V_ACTIVE   = DEF_V_ACTIVE,
  parameter int unsigned V_FP       = DEF_V_FP,
  parameter int unsigned V_SYNC     = DEF_V_SYNC,
  parameter int unsigned V_BP       = DEF_V_BP,
  parameter bit          H_SYNC_POL = 1'b0,
  parameter bit          V_SYNC_POL = 1'b0,
  parameter int unsigned CNT_W      = DEF_CNT_W,
  parameter int unsigned FRAME_W    = DEF_FRAME_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  output logic [CNT_W-1:0]   h_count,
  output logic [CNT_W-1:0]   v_count,
  output logic               hsync,
  output logic               vsync,
  output logic               active,
  output logic               line_end,
  output logic               frame_start,
  output logic [FRAME_W-1:0] frame_cnt
);

  // ---------------------------------------------------------------------------
  // Derived timing
  // ---------------------------------------------------------------------------
  localparam int unsigned H_TOTAL = calc_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned V_TOTAL = calc_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  localparam logic [CNT_W-1:0] H_MAX      = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT_END  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT_END  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_FIRST   = CNT_W'(sync_first(H_ACTIVE, H_FP));
  localparam logic [CNT_W-1:0] HS_LAST    = CNT_W'(sync_last(H_ACTIVE, H_FP, H_SYNC));
  localparam logic [CNT_W-1:0] VS_FIRST   = CNT_W'(sync_first(V_ACTIVE, V_FP));
  localparam logic [CNT_W-1:0] VS_LAST    = CNT_W'(sync_last(V_ACTIVE, V_FP, V_SYNC));

  // ---------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // ---------------------------------------------------------------------------
  if (!params_ok(H_ACTIVE, H_FP, H_SYNC, H_BP, CNT_W)) begin : g_bad_h_timing
    $error("vga_timing_gen: horizontal segment is zero or H_TOTAL-1 exceeds CNT_W");
  end
  if (!params_ok(V_ACTIVE, V_FP, V_SYNC, V_BP, CNT_W)) begin : g_bad_v_timing
    $error("vga_timing_gen: vertical segment is zero or V_TOTAL-1 exceeds CNT_W");
  end
  if (FRAME_W == 0) begin : g_bad_frame_w
    $error("vga_timing_gen: FRAME_W must be at least 1");
  end

  // ---------------------------------------------------------------------------
  // Raster position counters
  // ---------------------------------------------------------------------------
  logic h_at_max;
  logic v_at_max;
  logic v_inc;

  // The vertical counter steps on the edge that wraps the horizontal one.
  assign v_inc = en && h_at_max;

  wrap_counter #(
    .MAX (H_TOTAL - 1),
    .W   (CNT_W)
  ) u_h_counter (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc    (en),
    .count  (h_count),
    .at_max (h_at_max)
  );

  wrap_counter #(
    .MAX (V_TOTAL - 1),
    .W   (CNT_W)
  ) u_v_counter (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc    (v_inc),
    .count  (v_count),
    .at_max (v_at_max)
  );

  // ---------------------------------------------------------------------------
  // Position the counters move to on the next enabled edge. Decoded outputs
  // are registered from this so they never lag the counters by a pixel.
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] h_step;
  logic [CNT_W-1:0] v_step;

  always_comb begin
    h_step = h_at_max ? '0 : h_count + 1'b1;
    v_step = v_count;
    if (h_at_max) begin
      v_step = v_at_max ? '0 : v_count + 1'b1;
    end
  end

  logic hsync_next;
  logic vsync_next;
  logic active_next;
  logic line_end_next;
  logic frame_start_next;
  logic frame_wrap;

  always_comb begin
    hsync_next       = ((h_step >= HS_FIRST) && (h_step <= HS_LAST)) ? H_SYNC_POL : ~H_SYNC_POL;
    vsync_next       = ((v_step >= VS_FIRST) && (v_step <= VS_LAST)) ? V_SYNC_POL : ~V_SYNC_POL;
    active_next      = (h_step < H_ACT_END) && (v_step < V_ACT_END);
    line_end_next    = (h_step == H_MAX);
    frame_start_next = (h_step == '0) && (v_step == '0);
    frame_wrap       = h_at_max && v_at_max;
  end

  // ---------------------------------------------------------------------------
  // Output registers
  // ---------------------------------------------------------------------------
  logic               hsync_reg;
  logic               vsync_reg;
  logic               active_reg;
  logic               line_end_reg;
  logic               frame_start_reg;
  logic [FRAME_W-1:0] frame_cnt_reg;
  // Low until the first enabled edge after reset. The reset position sits at
  // the last pixel of a frame, so that first edge is a frame wrap that must
  // not be counted as a completed frame.
  logic               started_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hsync_reg       <= ~H_SYNC_POL;
      vsync_reg       <= ~V_SYNC_POL;
      active_reg      <= 1'b0;
      line_end_reg    <= 1'b1;
      frame_start_reg <= 1'b0;
      frame_cnt_reg   <= '0;
      started_reg     <= 1'b0;
    end else if (en) begin
      hsync_reg       <= hsync_next;
      vsync_reg       <= vsync_next;
      active_reg      <= active_next;
      line_end_reg    <= line_end_next;
      frame_start_reg <= frame_start_next;
      started_reg     <= 1'b1;
      if (frame_wrap && started_reg) begin
        frame_cnt_reg <= frame_cnt_reg + 1'b1;
      end
    end
  end

  assign hsync       = hsync_reg;
  assign vsync       = vsync_reg;
  assign active      = active_reg;
  assign line_end    = line_end_reg;
  assign frame_start = frame_start_reg;
  assign frame_cnt   = frame_cnt_reg;

endmodule

// File: tb/tb_vga_timing_gen.sv
// -----------------------------------------------------------------------------
// tb_vga_timing_gen
//   Two instances: default 640x480 timing and a tiny 8x6 raster with an
//   active-high hsync and 2-bit frame counter. A raster model derives every
//   output from the number of enabled edges since reset; a compare process
//   checks both instances against it on every falling clock edge, and the
//   stimulus adds directed literal checks.
// -----------------------------------------------------------------------------
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Raster model: position is a pure function of enabled-edge count t.
  // t==0 is the reset position (last pixel of the last line).
  // ---------------------------------------------------------------------------
  typedef struct packed {
    int h;
    int v;
    int fc;
    bit hs;
    bit vs;
    bit act;
    bit le;
    bit fs;
  } exp_t;

  function automatic exp_t model(input longint t,
                                 input int ha, input int hfp, input int hsw, input int hbp,
                                 input int va, input int vfp, input int vsw, input int vbp,
                                 input bit hpol, input bit vpol, input int fw);
    exp_t   e;
    longint ht;
    longint vt;
    longint p;
    ht = ha + hfp + hsw + hbp;
    vt = va + vfp + vsw + vbp;
    if (t == 0) begin
      e.h  = int'(ht - 1);
      e.v  = int'(vt - 1);
      e.fc = 0;
    end else begin
      p    = t - 1;
      e.h  = int'(p % ht);
      e.v  = int'((p / ht) % vt);
      e.fc = int'((p / (ht * vt)) % (longint'(1) << fw));
    end
    e.hs  = (e.h >= ha + hfp && e.h < ha + hfp + hsw) ? hpol : !hpol;
    e.vs  = (e.v >= va + vfp && e.v < va + vfp + vsw) ? vpol : !vpol;
    e.act = (e.h < ha) && (e.v < va);
    e.le  = (longint'(e.h) == ht - 1);
    e.fs  = (t != 0) && (e.h == 0) && (e.v == 0);
    return e;
  endfunction

  function automatic exp_t model_d(input longint t);
    return model(t, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0, 8);
  endfunction

  function automatic exp_t model_s(input longint t);
    return model(t, 4, 1, 2, 1, 3, 1, 1, 1, 1'b1, 1'b0, 2);
  endfunction

  // ---------------------------------------------------------------------------
  // DUT: default timing
  // ---------------------------------------------------------------------------
  logic       rst_d = 1'b1;
  logic       en_d  = 1'b0;
  logic [9:0] h_d, v_d;
  logic       hs_d, vs_d, act_d, le_d, fs_d;
  logic [7:0] fc_d;

  vga_timing_gen dut (
    .clk         (clk),
    .rst_n       (rst_d),
    .en          (en_d),
    .h_count     (h_d),
    .v_count     (v_d),
    .hsync       (hs_d),
    .vsync       (vs_d),
    .active      (act_d),
    .line_end    (le_d),
    .frame_start (fs_d),
    .frame_cnt   (fc_d)
  );

  // ---------------------------------------------------------------------------
  // DUT: tiny timing, H 4/1/2/1 (8), V 3/1/1/1 (6), active-high hsync
  // ---------------------------------------------------------------------------
  logic       rst_s = 1'b1;
  logic       en_s  = 1'b0;
  logic [3:0] h_s, v_s;
  logic       hs_s, vs_s, act_s, le_s, fs_s;
  logic [1:0] fc_s;

  vga_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b0),
    .CNT_W(4), .FRAME_W(2)
  ) dut_s (
    .clk         (clk),
    .rst_n       (rst_s),
    .en          (en_s),
    .h_count     (h_s),
    .v_count     (v_s),
    .hsync       (hs_s),
    .vsync       (vs_s),
    .active      (act_s),
    .line_end    (le_s),
    .frame_start (fs_s),
    .frame_cnt   (fc_s)
  );

  // Enabled-edge counters feeding the model
  longint t_d = 0;
  longint t_s = 0;

  always @(posedge clk or negedge rst_d) begin
    if (!rst_d) t_d <= 0;
    else if (en_d) t_d <= t_d + 1;
  end

  always @(posedge clk or negedge rst_s) begin
    if (!rst_s) t_s <= 0;
    else if (en_s) t_s <= t_s + 1;
  end

  // Per-cycle comparison against the model
  bit cmp_on = 1'b0;

  always @(negedge clk) begin
    exp_t ed;
    exp_t es;
    if (cmp_on) begin
      ed = model_d(t_d);
      chk("d.h_count",     h_d,   ed.h);
      chk("d.v_count",     v_d,   ed.v);
      chk("d.hsync",       hs_d,  ed.hs);
      chk("d.vsync",       vs_d,  ed.vs);
      chk("d.active",      act_d, ed.act);
      chk("d.line_end",    le_d,  ed.le);
      chk("d.frame_start", fs_d,  ed.fs);
      chk("d.frame_cnt",   fc_d,  ed.fc);
      es = model_s(t_s);
      chk("s.h_count",     h_s,   es.h);
      chk("s.v_count",     v_s,   es.v);
      chk("s.hsync",       hs_s,  es.hs);
      chk("s.vsync",       vs_s,  es.vs);
      chk("s.active",      act_s, es.act);
      chk("s.line_end",    le_s,  es.le);
      chk("s.frame_start", fs_s,  es.fs);
      chk("s.frame_cnt",   fc_s,  es.fc);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus and directed checks
  // ---------------------------------------------------------------------------
  initial begin
    exp_t   m;
    int     cnt;
    int     first_h;
    bit     found;
    int     prev_h;
    int     n_entry;
    int     entry_cyc[2];
    int     act_cnt[3];
    int     fc_seen[3];
    int     nfs;
    int     hs_hi;
    int     hs_first;
    int     vs_lo;

    // Hand-computed points that pin the model itself
    m = model_d(1);      chk("model.first_edge_h", m.h, 0);  chk("model.first_edge_fs", m.fs, 1);
    m = model_d(800);    chk("model.line_end_h", m.h, 799);  chk("model.line_end_le", m.le, 1);
    m = model_d(801);    chk("model.line1_v", m.v, 1);
    m = model_d(657);    chk("model.hsync_656", m.hs, 0);
    m = model_d(656);    chk("model.hsync_655", m.hs, 1);
    m = model_d(490*800 + 1); chk("model.vsync_490", m.vs, 0);
    m = model_d(525*800 + 1); chk("model.frame1_fc", m.fc, 1);
    m = model_s(6);      chk("model.s_hsync_5", m.hs, 1);

    // Reset (generate a real falling edge on both resets)
    #2;
    rst_d = 1'b0;
    rst_s = 1'b0;
    cmp_on = 1'b1;
    repeat (3) step();

    chk("d.rst_h",  h_d, 799);  chk("d.rst_v",  v_d, 524);
    chk("d.rst_hs", hs_d, 1);   chk("d.rst_vs", vs_d, 1);
    chk("d.rst_act", act_d, 0); chk("d.rst_le", le_d, 1);
    chk("d.rst_fs", fs_d, 0);   chk("d.rst_fc", fc_d, 0);
    chk("s.rst_h",  h_s, 7);    chk("s.rst_v",  v_s, 5);
    chk("s.rst_hs", hs_s, 0);   chk("s.rst_vs", vs_s, 1);

    // Release, en held high
    rst_d = 1'b1;
    en_d  = 1'b1;
    step();
    chk("d.first_h", h_d, 0);  chk("d.first_v", v_d, 0);
    chk("d.first_fs", fs_d, 1); chk("d.first_act", act_d, 1);
    chk("d.first_fc", fc_d, 0);
    repeat (799) step();
    chk("d.clk800_h", h_d, 799); chk("d.clk800_le", le_d, 1);
    step();
    chk("d.wrap_h", h_d, 0);   chk("d.wrap_v", v_d, 1);
    chk("d.wrap_le", le_d, 0);

    // hsync width and start over line 1
    cnt = 0; first_h = -1;
    repeat (800) begin
      step();
      if (hs_d == 1'b0) begin
        if (cnt == 0) first_h = int'(h_d);
        cnt++;
      end
    end
    chk("d.hsync_low_cycles", cnt, 96);
    chk("d.hsync_first_h", first_h, 656);

    // Reset mid-frame, between clock edges
    found = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      if (h_d == 10'd300 && v_d == 10'd2) begin
        found = 1'b1;
        break;
      end
      step();
    end
    chk("d.reach_h300_v2", found, 1);
    #2;
    rst_d = 1'b0;
    #1;
    chk("d.async_rst_h", h_d, 799);   chk("d.async_rst_v", v_d, 524);
    chk("d.async_rst_hs", hs_d, 1);   chk("d.async_rst_act", act_d, 0);
    chk("d.async_rst_le", le_d, 1);   chk("d.async_rst_fs", fs_d, 0);
    step();
    rst_d = 1'b1;
    step();
    chk("d.resume_h", h_d, 0);  chk("d.resume_v", v_d, 0);
    chk("d.resume_fs", fs_d, 1); chk("d.resume_fc", fc_d, 0);

    // en pulsed 1-of-4: line period in clocks
    n_entry = 0; prev_h = int'(h_d);
    for (int c = 0; c < 8000; c++) begin
      en_d = (c % 4 == 0);
      step();
      if (h_d == 10'd0 && prev_h != 0) begin
        entry_cyc[n_entry] = c;
        n_entry++;
      end
      prev_h = int'(h_d);
      if (n_entry == 2) break;
    end
    chk("d.quarter_en_entries", n_entry, 2);
    if (n_entry == 2) chk("d.quarter_en_line_period", entry_cyc[1] - entry_cyc[0], 3200);

    // Random enable
    repeat (3000) begin
      en_d = 1'($urandom_range(0, 1));
      step();
    end
    en_d = 1'b0;

    // Tiny raster: three frames with en high
    rst_s = 1'b1;
    en_s  = 1'b1;
    nfs = 0; hs_hi = 0; hs_first = -1; vs_lo = 0;
    for (int f = 0; f < 3; f++) act_cnt[f] = 0;
    for (int k = 1; k <= 144; k++) begin
      step();
      act_cnt[(k - 1) / 48] += int'(act_s);
      if (fs_s) begin
        if (nfs < 3) fc_seen[nfs] = int'(fc_s);
        nfs++;
      end
      if (k <= 8 && hs_s) begin
        if (hs_hi == 0) hs_first = int'(h_s);
        hs_hi++;
      end
      if (k <= 48 && !vs_s) vs_lo++;
    end
    chk("s.frame_starts", nfs, 3);
    for (int f = 0; f < 3; f++) begin
      chk($sformatf("s.fc_at_frame%0d", f), fc_seen[f], f);
      chk($sformatf("s.active_frame%0d", f), act_cnt[f], 12);
    end
    chk("s.hsync_high_cycles", hs_hi, 2);
    chk("s.hsync_first_h", hs_first, 5);
    chk("s.vsync_low_cycles", vs_lo, 8);

    // frame_cnt wraps modulo 4 at the start of frame 4
    repeat (49) step();
    chk("s.wrap_fs", fs_s, 1);
    chk("s.wrap_fc", fc_s, 0);

    // Random enable on the tiny raster
    repeat (400) begin
      en_s = 1'($urandom_range(0, 1));
      step();
    end
    en_s = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
